// File: rtl/pluck_profile_gen.sv
// pluck_profile_gen: run-time triangular pluck profile,
// streamed as (addr, data) beats into the node loader.
module pluck_profile_gen #(
  parameter int NUM_NODES = 30,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FRAC_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] amplitude,
  input  logic [ADDR_W-1:0] peak_lo,
  input  logic [ADDR_W-1:0] peak_hi,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int QW = DATA_W + FRAC_W;
  localparam int AW = QW + ADDR_W;
  localparam int CW = $clog2(QW);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_NODES - 1);
  localparam logic [ADDR_W:0] NN =
    (ADDR_W+1)'(NUM_NODES);
  localparam logic [CW-1:0] CNT_END = CW'(QW - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, DIV_UP, DIV_DN,
    EMIT_UP, EMIT_FLAT, EMIT_DN, FIN
  } state_t;

  state_t state, nxt;

  logic              mode_q;
  logic [DATA_W-1:0] amp_q;
  logic [ADDR_W-1:0] lo_q, hi_q;
  logic              cfg_err_q;
  logic [ADDR_W-1:0] rem_q;
  logic [QW-1:0]     quo_q;
  logic [CW-1:0]     cnt_q;
  logic [QW-1:0]     step_up_q, step_dn_q;
  logic [AW-1:0]     acc_q;
  logic [ADDR_W-1:0] addr_q;

  logic              accept, bad_cfg;
  logic              up_skip, dn_skip;
  logic [ADDR_W-1:0] flat_start, flat_end;
  logic [ADDR_W-1:0] dn_len, div_d;
  logic [ADDR_W:0]   rem_sh;
  logic              div_ge, div_last, xfer;
  logic [ADDR_W-1:0] rem_nx;
  logic [QW-1:0]     quo_nx, step_nx, dividend;

  assign accept = start &&
    (state == IDLE || state == FIN);
  assign bad_cfg = (lo_q > hi_q) ||
    ({1'b0, hi_q} >= NN);
  assign up_skip = lo_q == '0;
  assign dn_skip = hi_q == LAST;
  assign flat_start = mode_q ? '0 : lo_q;
  assign flat_end = mode_q ? LAST : hi_q;
  assign dn_len = LAST - hi_q;
  assign div_d = (state == DIV_UP) ? lo_q : dn_len;
  assign dividend = {amp_q, {FRAC_W{1'b0}}};

  // restoring divider: one quotient bit per cycle
  assign rem_sh = {rem_q, quo_q[QW-1]};
  assign div_ge = rem_sh >= {1'b0, div_d};
  assign rem_nx = ADDR_W'(div_ge ?
    rem_sh - {1'b0, div_d} : rem_sh);
  assign quo_nx = {quo_q[QW-2:0], div_ge};
  assign step_nx = quo_nx + QW'(rem_nx != '0);
  assign div_last = cnt_q == CNT_END;
  assign xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) nxt = CHECK;
      CHECK: begin
        if (mode_q)        nxt = EMIT_FLAT;
        else if (bad_cfg)  nxt = FIN;
        else if (!up_skip) nxt = DIV_UP;
        else if (!dn_skip) nxt = DIV_DN;
        else               nxt = EMIT_FLAT;
      end
      DIV_UP:
        if (div_last) nxt = dn_skip ? EMIT_UP : DIV_DN;
      DIV_DN:
        if (div_last) nxt = up_skip ? EMIT_FLAT : EMIT_UP;
      EMIT_UP:
        if (xfer && addr_q == lo_q - ADDR_W'(1))
          nxt = EMIT_FLAT;
      EMIT_FLAT:
        if (xfer && addr_q == flat_end)
          nxt = (mode_q || dn_skip) ? FIN : EMIT_DN;
      EMIT_DN:
        if (xfer && addr_q == hi_q + ADDR_W'(1))
          nxt = FIN;
      FIN: nxt = accept ? CHECK : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= 1'b0;
      amp_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      cfg_err_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      step_up_q <= '0;
      step_dn_q <= '0;
      acc_q     <= '0;
      addr_q    <= '0;
    end else begin
      if (accept) begin
        mode_q    <= mode;
        amp_q     <= amplitude;
        lo_q      <= peak_lo;
        hi_q      <= peak_hi;
        cfg_err_q <= 1'b0;
      end
      unique case (state)
        CHECK: begin
          cfg_err_q <= !mode_q && bad_cfg;
          rem_q     <= '0;
          quo_q     <= dividend;
          cnt_q     <= '0;
        end
        DIV_UP, DIV_DN: begin
          if (div_last) begin
            if (state == DIV_UP) step_up_q <= step_nx;
            else                 step_dn_q <= step_nx;
            rem_q <= '0;
            quo_q <= dividend;
            cnt_q <= '0;
          end else begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        EMIT_UP: if (xfer) begin
          addr_q <= addr_q + ADDR_W'(1);
          acc_q  <= acc_q + AW'(step_up_q);
        end
        EMIT_FLAT: if (xfer)
          addr_q <= addr_q + ADDR_W'(1);
        EMIT_DN: if (xfer) begin
          addr_q <= addr_q - ADDR_W'(1);
          acc_q  <= acc_q + AW'(step_dn_q);
        end
        default: ;
      endcase
      // each emit phase restarts its address and ramp
      if (nxt != state) begin
        unique case (nxt)
          EMIT_UP:   addr_q <= '0;
          EMIT_FLAT: addr_q <= flat_start;
          EMIT_DN:   addr_q <= LAST;
          default: ;
        endcase
        acc_q <= '0;
      end
    end
  end

  always_comb begin
    busy      = (state != IDLE) && (state != FIN);
    done      = state == FIN;
    cfg_err   = cfg_err_q;
    out_valid = 1'b0;
    out_addr  = '0;
    out_data  = '0;
    out_last  = 1'b0;
    unique case (state)
      EMIT_UP: begin
        out_valid = 1'b1;
        out_addr  = addr_q;
        out_data  = acc_q[FRAC_W +: DATA_W];
      end
      EMIT_FLAT: begin
        out_valid = 1'b1;
        out_addr  = addr_q;
        out_data  = mode_q ? '0 : amp_q;
        out_last  = (addr_q == flat_end) &&
                    (mode_q || dn_skip);
      end
      EMIT_DN: begin
        out_valid = 1'b1;
        out_addr  = addr_q;
        out_data  = acc_q[FRAC_W +: DATA_W];
        out_last  = addr_q == hi_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pluck_profile_gen.sv
// tb_pluck_profile_gen: random configs vs. arithmetic model,
// scoreboard queue drained by a negedge monitor.
module tb_pluck_profile_gen;
  localparam int N = 30;

  typedef longint unsigned u64;
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] amplitude = '0;
  logic [4:0]  peak_lo = '0;
  logic [4:0]  peak_hi = '0;
  logic        out_ready = 1'b1;
  logic        busy, done, cfg_err;
  logic        out_valid, out_last;
  logic [4:0]  out_addr;
  logic [31:0] out_data;

  pluck_profile_gen #(
    .NUM_NODES(30), .ADDR_W(5),
    .DATA_W(32), .FRAC_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .mode(mode), .amplitude(amplitude),
    .peak_lo(peak_lo), .peak_hi(peak_hi),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .out_last(out_last)
  );

  initial forever #5 clk = ~clk;

  beat_t q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    beat_cnt = 0;
  bit    rdy_rand = 1'b0;
  bit    chk_tp = 1'b0;

  function automatic logic [31:0] prof(
    int i, logic [31:0] a, int lo, int hi);
    u64 num;
    if (i < lo)
      num = (u64'(i) * u64'(a)) / u64'(lo);
    else if (i <= hi)
      num = u64'(a);
    else
      num = (u64'(N - 1 - i) * u64'(a)) /
            u64'(N - 1 - hi);
    return num[31:0];
  endfunction

  // published values for A=0x8000, L=14, H=15
  function automatic logic [32:0] tp_val(
    logic [4:0] a);
    case (a)
      5'd1, 5'd28: return {1'b1, 32'h0924};
      5'd2:        return {1'b1, 32'h1249};
      5'd3:        return {1'b1, 32'h1B6D};
      5'd7:        return {1'b1, 32'h4000};
      5'd13, 5'd16: return {1'b1, 32'h76DB};
      5'd14, 5'd15: return {1'b1, 32'h8000};
      5'd29:       return {1'b1, 32'h0};
      default:     return 33'h0;
    endcase
  endfunction

  task automatic push_profile(
    input bit m, input logic [31:0] a,
    input int lo, input int hi);
    int    idx[$];
    beat_t b;
    if (m) begin
      for (int i = 0; i < N; i++) idx.push_back(i);
    end else begin
      for (int i = 0; i < lo; i++) idx.push_back(i);
      for (int i = lo; i <= hi; i++) idx.push_back(i);
      for (int i = N - 1; i > hi; i--) idx.push_back(i);
    end
    for (int k = 0; k < idx.size(); k++) begin
      b.addr = 5'(idx[k]);
      b.data = m ? 32'h0 : prof(idx[k], a, lo, hi);
      b.last = (k == idx.size() - 1);
      q.push_back(b);
    end
  endtask

  task automatic chk(input string name,
    input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_addr"}, 64'(out_addr), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_last"}, 64'(out_last), 64'd0);
  endtask

  task automatic issue(input bit m,
    input logic [31:0] a, input int lo, input int hi);
    @(posedge clk); #1;
    start = 1'b1; mode = m; amplitude = a;
    peak_lo = 5'(lo); peak_hi = 5'(hi);
    @(posedge clk); #1;
    start = 1'b0;
    mode = 1'($urandom);
    amplitude = $urandom;
    peak_lo = 5'($urandom);
    peak_hi = 5'($urandom);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("cfg_err_cleared", 64'(cfg_err), 64'd0);
  endtask

  task automatic wait_done(input bit exp_err);
    bit seen = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL done_timeout: got no done, expected done");
      q.delete();
    end else begin
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("cfg_err_at_done", 64'(cfg_err), 64'(exp_err));
      chk("beats_left_at_done", 64'(q.size()), 64'd0);
    end
  endtask

  task automatic run(input bit m,
    input logic [31:0] a, input int lo, input int hi,
    input bit poke);
    bit exp_err;
    exp_err = !m && (lo > hi || hi >= N);
    if (!exp_err) push_profile(m, a, lo, hi);
    issue(m, a, lo, hi);
    if (poke && !exp_err) begin
      repeat (3) @(posedge clk);
      #1;
      if (busy) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    wait_done(exp_err);
  endtask

  initial forever begin
    @(posedge clk); #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor: pops the scoreboard on every accepted beat
  bit          have_hold = 1'b0;
  bit          exp_done = 1'b0;
  logic [4:0]  h_addr;
  logic [31:0] h_data;
  logic        h_last;
  beat_t       e;
  logic [32:0] tv;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      have_hold = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (exp_done) begin
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL done_after_last: done=%b busy=%b, expected 1 0",
                   done, busy);
        end
        exp_done = 1'b0;
      end
      if (have_hold) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_addr !== h_addr ||
            out_data !== h_data || out_last !== h_last) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b a=%0d d=%h l=%b, expected v=1 a=%0d d=%h l=%b",
                   out_valid, out_addr, out_data, out_last,
                   h_addr, h_data, h_last);
        end
      end
      have_hold = 1'b0;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        beat_cnt++;
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got addr=%0d data=%h, expected no beat",
                   out_addr, out_data);
        end else begin
          e = q.pop_front();
          if (out_addr !== e.addr || out_data !== e.data ||
              out_last !== e.last) begin
            n_err++;
            $display("FAIL beat: got a=%0d d=%h l=%b, expected a=%0d d=%h l=%b",
                     out_addr, out_data, out_last,
                     e.addr, e.data, e.last);
          end
          if (e.last) exp_done = 1'b1;
          if (chk_tp) begin
            tv = tp_val(out_addr);
            if (tv[32]) begin
              n_vec++;
              if (out_data !== tv[31:0]) begin
                n_err++;
                $display("FAIL tp_value addr %0d: got %h, expected %h",
                         out_addr, out_data, tv[31:0]);
              end
            end
          end
        end
      end else if (out_valid === 1'b1) begin
        have_hold = 1'b1;
        h_addr = out_addr;
        h_data = out_data;
        h_last = out_last;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          base;
    bit          hit;
    bit          m;
    int          lo, hi;
    logic [31:0] a;

    repeat (2) @(posedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("post_reset");
    chk("cfg_err_reset", 64'(cfg_err), 64'd0);

    chk_tp = 1'b1;
    rdy_rand = 1'b0;
    run(1'b0, 32'h8000, 14, 15, 1'b0);
    rdy_rand = 1'b1;
    run(1'b0, 32'h8000, 14, 15, 1'b0);
    chk_tp = 1'b0;

    run(1'b0, 32'hFFFF_FFFF, 0, 29, 1'b0);
    run(1'b1, 32'h1234, 20, 10, 1'b0);

    run(1'b0, $urandom, 20, 10, 1'b0);
    repeat (3) @(negedge clk);
    chk("cfg_err_sticky", 64'(cfg_err), 64'd1);
    run(1'b0, 32'h0, 3, 20, 1'b1);

    // reset in the middle of the up ramp
    rdy_rand = 1'b0;
    push_profile(1'b0, 32'h8000, 14, 15);
    base = beat_cnt;
    issue(1'b0, 32'h8000, 14, 15);
    hit = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (beat_cnt >= base + 6) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_addr5", 64'(hit), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run(1'b0, 32'h8000, 14, 15, 1'b1);

    for (int t = 0; t < 14; t++) begin
      rdy_rand = 1'($urandom);
      m = ($urandom_range(0, 7) == 0);
      lo = $urandom_range(0, N - 1);
      hi = $urandom_range(lo, N - 1);
      if ($urandom_range(0, 7) == 0) begin
        lo = $urandom_range(0, 31);
        hi = $urandom_range(0, 31);
      end
      case ($urandom_range(0, 3))
        0: a = 32'h0;
        1: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      run(m, a, lo, hi, 1'b1);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
